fifo_push_arbiter: RTL and testbench
====================================

# fifo_push_arbiter

Round-robin write-side arbiter that shares one `FIFO` instance between `N` producers. Each producer presents words on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and forwards accepted words to the FIFO's `push`/`data_push` port one cycle later. It tracks FIFO occupancy itself through a credit counter, so it never pushes into a full FIFO and does not depend on the FIFO's registered `full`/`almost_full` flags.

## Interface
- `N`, 4: number of requesters (≥2).
- `WL`, 8: data word width; equals the FIFO's `wL`.
- `DEPTH`, 8: FIFO depth in words; equals the FIFO's `d`.
- `BURST`, 4: maximum words per grant (≥1).
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req_valid` in N: bit i = requester i has a word.
- `req_data` in N*WL: word of requester i at bits [i*WL +: WL].
- `req_ready` out N: bit i = word of requester i accepted this cycle if valid.
- `fifo_pop` in 1: FIFO consumer popped a word this cycle; returns one credit.
- `fifo_push` out 1: registered push strobe to FIFO.
- `fifo_data` out WL: registered word to FIFO `data_push`.
- `grant_id` out $clog2(N): current or last owner index.
- `busy` out 1: high while in GRANT.

## Operation
- Transfer: requester i transfers in a cycle when `req_valid[i] && req_ready[i]`. At most one ready bit is high per cycle.
- FSM states: IDLE and GRANT.
- IDLE:
  - `req_ready` = 0.
  - If any `req_valid` bit is set, pick the first set bit searching from `(last_owner+1) mod N` upward with wrap.
  - Load `owner` and `last_owner`, clear `burst_cnt`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `req_ready[owner] = (credit != 0)`, combinational from registered state. All other ready bits are 0.
  - Each transfer increments `burst_cnt`.
  - Go to IDLE after a cycle in which `req_valid[owner]` = 0, or a cycle in which the transfer brings `burst_cnt` to `BURST`.
  - With credit 0 and owner valid, stay in GRANT with ready low (stall). `burst_cnt` holds and the stall does not count toward the burst.
- Credit counter, width $clog2(DEPTH+1):
  - `credit_next = credit - xfer + fifo_pop`.
  - Transfer and pop in the same cycle leave credit unchanged.
  - A pop at `credit == DEPTH` is ignored (saturates; no wrap).
  - Credit 0 blocks all transfers. `DEPTH` consecutive transfers with no pops exhaust credit.
- Datapath: on a transfer, `fifo_data <= req_data[owner]` and `fifo_push <= 1`; otherwise `fifo_push <= 0` and `fifo_data` holds.
- Fairness: after a burst ends, the same requester is not re-granted while any other requester is valid in the IDLE cycle.
- Reset values:
  - state IDLE, `credit = DEPTH`, `last_owner = N-1` (requester 0 has first priority).
  - `owner = 0`, `grant_id = 0`, `burst_cnt = 0`.
  - `fifo_push = 0`, `fifo_data = 0`, `busy = 0`, `req_ready = 0`.
- Reset mid-burst: the cycle after `rst` low, all state returns to reset values. An in-flight registered push is dropped (`fifo_push = 0`). The FIFO is reset on the same `rst`, so credit and occupancy stay consistent.

## Timing
- Arbitration: `req_valid` high in IDLE at edge k → GRANT and `req_ready` (if credit > 0) during cycle k+1.
- Push latency: a transfer in cycle t produces `fifo_push = 1` with its data in cycle t+1.
- Peak throughput inside a burst: 1 word/cycle.
- Every grant change costs exactly one IDLE bubble cycle, so sustained throughput with all requesters valid is BURST/(BURST+1).
- Credit returned by `fifo_pop` in cycle t is usable for a transfer in cycle t+1.
- `grant_id` and `busy` are registered and change on the edge that enters GRANT or IDLE.

## Test plan
- **Reset:** hold `rst` = 0 for 2 cycles with all `req_valid` high.
  - Required: `req_ready` = 0, `fifo_push` = 0, `busy` = 0.
  - Required: first grant after release goes to requester 0 (`grant_id` = 0).
- **Single requester burst:** requester 2 valid continuously with data 0xA0, 0xA1, …, pops every cycle.
  - Required: 4 pushes 0xA0–0xA3 with `grant_id` = 2, then 1 bubble.
  - Required: re-grant to 2, then 0xA4… continues.
- **Round-robin:** all 4 requesters valid continuously, pops every cycle.
  - Required: grant order 0, 1, 2, 3, 0, with 4 words each.
  - Required: exactly one IDLE cycle between grants, and no cycle with two ready bits high.
- **Credit exhaustion:** `DEPTH` = 8, no pops, requester 1 valid.
  - Required: exactly 8 transfers total across re-grants, then `req_ready` stays 0.
  - Then pulse `fifo_pop` once: exactly one more transfer, in the following cycle.
- **Simultaneous pop/transfer:** at credit 1, transfer and `fifo_pop` in the same cycle.
  - Required: credit stays 1 and the next word transfers the following cycle.
  - Also: `fifo_pop` at credit 8 leaves credit at 8.
- **Reset mid-burst and early release:**
  - Assert `rst` during the 2nd word of a burst. Required: `fifo_push` = 0 next cycle and credit = 8.
  - Separately, the owner drops valid after 1 word. Required: return to IDLE next cycle and grant the next valid requester.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// Round-robin write-side arbiter that shares one FIFO between N producers.
// Tracks FIFO occupancy with a credit counter and drives a registered push port.
module fifo_push_arbiter #(
  parameter int N     = 4,
  parameter int WL    = 8,
  parameter int DEPTH = 8,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WL-1:0]      req_data,
  output logic [N-1:0]         req_ready,
  input  logic                 fifo_pop,
  output logic                 fifo_push,
  output logic [WL-1:0]        fifo_data,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);
  localparam int          OW = $clog2(N);
  localparam int          CW = $clog2(DEPTH + 1);
  localparam int          BW = $clog2(BURST + 1);
  localparam int unsigned NU = N;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_next;
  logic [OW-1:0] owner, last_owner, pick;
  logic [BW-1:0] burst_cnt;
  logic [CW-1:0] credit, credit_next;
  logic          has_credit, any_valid, xfer, burst_done;
  int unsigned   idx;

  assign has_credit = (credit != '0);
  assign any_valid  = |req_valid;
  assign grant_id   = owner;
  assign busy       = (state == GRANT);

  // Scan from farthest to nearest so the nearest valid requester after last_owner wins.
  always_comb begin
    pick = last_owner;
    idx  = 0;
    for (int unsigned k = NU; k > 0; k--) begin
      idx = (32'(last_owner) + k) % NU;
      if (req_valid[idx[OW-1:0]]) pick = idx[OW-1:0];
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    xfer       = 1'b0;
    burst_done = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) state_next = GRANT;
      end
      GRANT: begin
        req_ready[owner] = has_credit;
        xfer             = req_valid[owner] && has_credit;
        burst_done       = xfer && (burst_cnt == BW'(BURST - 1));
        if (!req_valid[owner] || burst_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A pop arriving with the FIFO already empty (credit full) is dropped.
  always_comb begin
    credit_next = credit;
    if (xfer && !fifo_pop)
      credit_next = credit - 1'b1;
    else if (!xfer && fifo_pop && (credit != CW'(DEPTH)))
      credit_next = credit + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      credit     <= CW'(DEPTH);
      last_owner <= OW'(N - 1);
      owner      <= '0;
      burst_cnt  <= '0;
      fifo_push  <= 1'b0;
      fifo_data  <= '0;
    end else begin
      state     <= state_next;
      credit    <= credit_next;
      fifo_push <= xfer;
      if (xfer) begin
        fifo_data <= req_data[owner*WL +: WL];
        burst_cnt <= burst_cnt + 1'b1;
      end
      if ((state == IDLE) && any_valid) begin
        owner      <= pick;
        last_owner <= pick;
        burst_cnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: vector table, directed corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_fifo_push_arbiter;
  localparam int N     = 4;
  localparam int WL    = 8;
  localparam int DEPTH = 8;
  localparam int BURST = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*WL-1:0] req_data;
  logic            fifo_pop, fifo_push;
  logic [WL-1:0]   fifo_data;
  logic [1:0]      grant_id;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WL-1:0] base [N];
  int            seq  [N];

  typedef struct {
    logic [N-1:0]  v;
    logic          p;
    logic [N-1:0]  rdy;
    logic          push;
    logic [WL-1:0] data;
    logic          bsy;
    logic [1:0]    gid;
  } vec_t;
  vec_t tbl [12];

  int            m_owner, m_last, m_words, m_credit, m_gid;
  logic          m_push;
  logic [WL-1:0] m_data;
  logic [N-1:0]  v, exp_rdy;
  logic          p, xf;
  int            cnt;

  fifo_push_arbiter #(.N(N), .WL(WL), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_pop(fifo_pop), .fifo_push(fifo_push),
    .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N*WL-1:0] pack_data();
    logic [N*WL-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*WL +: WL] = base[i] + WL'(seq[i]);
    return r;
  endfunction

  task automatic drive(input logic [N-1:0] vv, input logic pp);
    req_valid = vv;
    fifo_pop  = pp;
    req_data  = pack_data();
  endtask

  // Called after sampling; moves to 1 time unit past the next rising edge.
  task automatic advance();
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) seq[i]++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) seq[i] = 0;
    rst = 1'b0;
    drive('0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    base[0] = 8'h30; base[1] = 8'h60; base[2] = 8'hA0; base[3] = 8'hC0;
    for (int i = 0; i < N; i++) seq[i] = 0;

    // Single-requester burst with re-grant, then early release to the next requester.
    tbl[0]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b1, 2'd2};
    tbl[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA0, 1'b1, 2'd2};
    tbl[3]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA1, 1'b1, 2'd2};
    tbl[4]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b1, 2'd2};
    tbl[5]  = '{4'b0100, 1'b1, 4'b0000, 1'b1, 8'hA3, 1'b0, 2'd2};
    tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 8'hA3, 1'b1, 2'd2};
    tbl[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA4, 1'b1, 2'd2};
    tbl[8]  = '{4'b1001, 1'b0, 4'b0100, 1'b1, 8'hA5, 1'b1, 2'd2};
    tbl[9]  = '{4'b1001, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd2};
    tbl[10] = '{4'b1001, 1'b0, 4'b1000, 1'b0, 8'hA5, 1'b1, 2'd3};
    tbl[11] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 8'hC0, 1'b1, 2'd3};

    // Reset held with every requester valid.
    rst = 1'b0;
    drive('1, 1'b0);
    @(posedge clk);
    #1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", req_ready, '0);
      chk("rst_push", fifo_push, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_idle_ready", req_ready, '0);
    advance();
    @(negedge clk);
    chk("first_grant_id", grant_id, 2'd0);
    chk("first_grant_busy", busy, 1'b1);
    chk("first_grant_ready", req_ready, 4'b0001);

    do_reset();
    for (int r = 0; r < 12; r++) begin
      drive(tbl[r].v, tbl[r].p);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].rdy);
      chk($sformatf("tbl%0d_push", r), fifo_push, tbl[r].push);
      chk($sformatf("tbl%0d_data", r), fifo_data, tbl[r].data);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].bsy);
      chk($sformatf("tbl%0d_gid", r), grant_id, tbl[r].gid);
      advance();
    end

    // Round-robin: bursts of BURST words separated by one idle cycle.
    do_reset();
    for (int c = 0; c < 25; c++) begin
      drive('1, 1'b1);
      @(negedge clk);
      exp_rdy = ((c % 5) == 0) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
      chk($sformatf("rr%0d_ready", c), req_ready, exp_rdy);
      advance();
    end

    // Credit exhaustion, preceded by pops at full credit that must be ignored.
    do_reset();
    repeat (3) begin
      drive('0, 1'b1);
      advance();
    end
    cnt = 0;
    for (int c = 0; c < 22; c++) begin
      drive(4'b0010, 1'b0);
      @(negedge clk);
      if (req_ready[1]) cnt++;
      if (c == 21) chk("exhaust_ready_low", req_ready, '0);
      advance();
    end
    chk("exhaust_xfer_count", cnt, DEPTH);
    drive(4'b0010, 1'b1);
    @(negedge clk);
    chk("pop_cycle_ready", req_ready, '0);
    advance();
    drive(4'b0010, 1'b0);
    @(negedge clk);
    chk("post_pop_xfer", req_ready, 4'b0010);
    advance();
    cnt = 0;
    repeat (4) begin
      drive(4'b0010, 1'b0);
      @(negedge clk);
      if (req_ready != '0) cnt++;
      advance();
    end
    chk("post_pop_no_extra", cnt, 0);

    // Transfer and pop in the same cycle at credit 1.
    drive(4'b0010, 1'b1);
    @(negedge clk);
    chk("simul_pre_ready", req_ready, '0);
    advance();
    drive(4'b0010, 1'b1);
    @(negedge clk);
    chk("simul_ready", req_ready, 4'b0010);
    advance();
    drive(4'b0010, 1'b0);
    @(negedge clk);
    chk("simul_next_ready", req_ready, 4'b0010);
    advance();
    drive(4'b0010, 1'b0);
    @(negedge clk);
    chk("simul_drained", req_ready, '0);
    advance();

    // Reset asserted while the second word of a burst transfers.
    do_reset();
    drive(4'b0001, 1'b0);
    advance();
    drive(4'b0001, 1'b0);
    advance();
    drive(4'b0001, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ready_before_rst", req_ready, 4'b0001);
    advance();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_push", fifo_push, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    advance();
    cnt = 0;
    for (int c = 0; c < 22; c++) begin
      drive(4'b0001, 1'b0);
      @(negedge clk);
      if (req_ready[0]) cnt++;
      advance();
    end
    chk("mid_rst_credit_full", cnt, DEPTH);

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_owner = -1; m_last = N - 1; m_words = 0; m_credit = DEPTH; m_gid = 0;
    m_push = 1'b0; m_data = '0;
    v = '0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
      p = ($urandom_range(0, 99) < 45);
      drive(v, p);
      @(negedge clk);
      exp_rdy = (m_owner >= 0 && m_credit > 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("rand_ready", req_ready, exp_rdy);
      chk("rand_push", fifo_push, m_push);
      chk("rand_data", fifo_data, m_data);
      chk("rand_busy", busy, (m_owner >= 0));
      chk("rand_gid", grant_id, m_gid[1:0]);
      xf = (m_owner >= 0) && (m_credit > 0) && v[m_owner];
      m_push = xf;
      if (xf) begin
        m_data = req_data[m_owner*WL +: WL];
        m_words++;
      end
      m_credit = m_credit - (xf ? 1 : 0) + (p ? 1 : 0);
      if (m_credit > DEPTH) m_credit = DEPTH;
      if (m_owner < 0) begin
        for (int d = 1; d <= N; d++) begin
          if (v[(m_last + d) % N]) begin
            m_owner = (m_last + d) % N;
            m_last  = m_owner;
            m_gid   = m_owner;
            m_words = 0;
            break;
          end
        end
      end else if (!v[m_owner] || m_words == BURST) begin
        m_owner = -1;
      end
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
